// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the memory-port arbiter.
// The master modport is the arbiter's view; the slave modport is the caches plus memory.
interface mem_arbiter_if #(
  parameter int BEAT_W = 2
);
  logic              ic_req;
  logic [31:0]       ic_addr;
  logic              ic_grant;
  logic              ic_rvalid;
  logic              ic_done;
  logic              dc_req;
  logic              dc_we;
  logic [31:0]       dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_grant;
  logic              dc_rvalid;
  logic              dc_done;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       rdata;
  logic [BEAT_W-1:0] rbeat;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              busy;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    output ic_grant, ic_rvalid, ic_done, dc_grant, dc_rvalid, dc_done,
           beat, rdata, rbeat, mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
    input  ic_grant, ic_rvalid, ic_done, dc_grant, dc_rvalid, dc_done,
           beat, rdata, rbeat, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (icache / dcache) arbiter for the single main-memory port.
// Each grant runs a LINE_WORDS-beat burst with per-beat req/ack, then a one-cycle DONE.
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int BEAT_W     = 2
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_WORDS - 1);

  state_e                state_q, state_d;
  logic                  owner_dc_q, owner_dc_d;
  logic                  last_dc_q, last_dc_d;
  logic                  we_q, we_d;
  logic [31:BEAT_W+2]    base_q, base_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [BEAT_W-1:0]     rbeat_q, rbeat_d;
  logic                  ic_grant_q, ic_grant_d;
  logic                  dc_grant_q, dc_grant_d;
  logic                  mem_req_q, mem_req_d;
  logic                  ic_rvalid_q, ic_rvalid_d;
  logic                  dc_rvalid_q, dc_rvalid_d;
  logic                  ic_done_q, ic_done_d;
  logic                  dc_done_q, dc_done_d;
  logic                  pick_dc_s;
  logic                  unused_s;

  // On a tie the requester that did not own the port last time wins.
  assign pick_dc_s = bus.dc_req & (~bus.ic_req | ~last_dc_q);
  assign unused_s  = ^{bus.ic_addr[BEAT_W+1:0], bus.dc_addr[BEAT_W+1:0]};

  // Next-state and next-output decode for the arbitration/burst FSM.
  always_comb begin
    state_d     = state_q;
    owner_dc_d  = owner_dc_q;
    last_dc_d   = last_dc_q;
    we_d        = we_q;
    base_d      = base_q;
    beat_d      = beat_q;
    rdata_d     = rdata_q;
    rbeat_d     = rbeat_q;
    ic_grant_d  = ic_grant_q;
    dc_grant_d  = dc_grant_q;
    mem_req_d   = mem_req_q;
    ic_rvalid_d = 1'b0;
    dc_rvalid_d = 1'b0;
    ic_done_d   = 1'b0;
    dc_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ic_req || bus.dc_req) begin
          state_d    = S_BURST;
          owner_dc_d = pick_dc_s;
          we_d       = pick_dc_s & bus.dc_we;
          base_d     = pick_dc_s ? bus.dc_addr[31:BEAT_W+2] : bus.ic_addr[31:BEAT_W+2];
          beat_d     = {BEAT_W{1'b0}};
          ic_grant_d = ~pick_dc_s;
          dc_grant_d = pick_dc_s;
          mem_req_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (bus.mem_ack) begin
          if (!we_q) begin
            rdata_d     = bus.mem_rdata;
            rbeat_d     = beat_q;
            ic_rvalid_d = ~owner_dc_q;
            dc_rvalid_d = owner_dc_q;
          end else begin
            rdata_d = rdata_q;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LastBeat) begin
            state_d   = S_DONE;
            mem_req_d = 1'b0;
            ic_done_d = ~owner_dc_q;
            dc_done_d = owner_dc_q;
          end else begin
            state_d = S_BURST;
          end
        end else begin
          state_d = S_BURST;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        last_dc_d  = owner_dc_q;
        beat_d     = {BEAT_W{1'b0}};
        ic_grant_d = 1'b0;
        dc_grant_d = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        ic_grant_d = 1'b0;
        dc_grant_d = 1'b0;
        mem_req_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset aborts any burst without a done pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      owner_dc_q  <= 1'b0;
      last_dc_q   <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      beat_q      <= {BEAT_W{1'b0}};
      rdata_q     <= 32'h0;
      rbeat_q     <= {BEAT_W{1'b0}};
      ic_grant_q  <= 1'b0;
      dc_grant_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_done_q   <= 1'b0;
      dc_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dc_q  <= owner_dc_d;
      last_dc_q   <= last_dc_d;
      we_q        <= we_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      rdata_q     <= rdata_d;
      rbeat_q     <= rbeat_d;
      ic_grant_q  <= ic_grant_d;
      dc_grant_q  <= dc_grant_d;
      mem_req_q   <= mem_req_d;
      ic_rvalid_q <= ic_rvalid_d;
      dc_rvalid_q <= dc_rvalid_d;
      ic_done_q   <= ic_done_d;
      dc_done_q   <= dc_done_d;
    end
  end

  assign bus.ic_grant  = ic_grant_q;
  assign bus.dc_grant  = dc_grant_q;
  assign bus.ic_rvalid = ic_rvalid_q;
  assign bus.dc_rvalid = dc_rvalid_q;
  assign bus.ic_done   = ic_done_q;
  assign bus.dc_done   = dc_done_q;
  assign bus.beat      = beat_q;
  assign bus.rdata     = rdata_q;
  assign bus.rbeat     = rbeat_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_req_q & we_q;
  // The beat counter occupies the word-index bits, so addresses wrap inside the line.
  assign bus.mem_addr  = mem_req_q ? {base_q, beat_q, 2'b00} : 32'h0;
  // dcache presents the word for the current beat; pass it straight through.
  assign bus.mem_wdata = (mem_req_q & we_q & owner_dc_q) ? bus.dc_wdata : 32'h0;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard of expected memory beats and read
// returns is filled when a request is issued and drained as the DUT produces them.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  beat;
  } beat_t;

  typedef struct {
    logic [1:0]  rbeat;
    logic [31:0] rdata;
  } rd_t;

  logic clk;
  logic reset_ni;
  int   n_cmp;
  int   n_err;
  beat_t exp_beats[$];
  rd_t   exp_rd[$];

  mem_arbiter_if #(.BEAT_W(2)) bus ();

  mem_arbiter #(.LINE_WORDS(4), .BEAT_W(2)) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_burst(input logic [31:0] addr, input logic we);
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      rd_t   r;
      e.beat  = 2'(b);
      e.addr  = {addr[31:4], e.beat, 2'b00};
      e.we    = we;
      e.wdata = we ? (32'hD0 + 32'(b)) : 32'h0;
      exp_beats.push_back(e);
      if (!we) begin
        r.rbeat = 2'(b);
        r.rdata = 32'hA0 + 32'(b);
        exp_rd.push_back(r);
      end
    end
  endtask

  // Acts as memory and checker until the owner's done pulse; dly = wait cycles per beat.
  task automatic serve(input logic exp_dc, input int dly, input int drop_after);
    int    waitc = 0;
    int    acks  = 0;
    int    cyc   = 0;
    logic  got_done = 1'b0;
    beat_t e;
    rd_t   r;
    while (!got_done && cyc < 200) begin
      cyc++;
      bus.mem_ack = 1'b0;
      if (bus.ic_rvalid || bus.dc_rvalid) begin
        if (exp_rd.size() == 0) begin
          chk("rvalid_unexpected", 32'(bus.ic_rvalid | bus.dc_rvalid), 32'h0);
        end else begin
          r = exp_rd.pop_front();
          chk("rvalid_owner_dc", 32'(bus.dc_rvalid), 32'(exp_dc));
          chk("rvalid_owner_ic", 32'(bus.ic_rvalid), 32'(!exp_dc));
          chk("rdata", bus.rdata, r.rdata);
          chk("rbeat", 32'(bus.rbeat), 32'(r.rbeat));
        end
      end
      chk("grant_exclusive", 32'(bus.ic_grant & bus.dc_grant), 32'h0);
      if (bus.busy) begin
        chk("owner_grant", 32'(exp_dc ? bus.dc_grant : bus.ic_grant), 32'h1);
      end
      if (bus.ic_done || bus.dc_done) begin
        chk("done_dc", 32'(bus.dc_done), 32'(exp_dc));
        chk("done_ic", 32'(bus.ic_done), 32'(!exp_dc));
        chk("beats_left_at_done", 32'(exp_beats.size()), 32'h0);
        chk("reads_left_at_done", 32'(exp_rd.size()), 32'h0);
        got_done = 1'b1;
      end
      if (bus.mem_req) begin
        bus.dc_wdata = 32'hD0 + 32'(bus.beat);
        #1;
        if (exp_beats.size() == 0) begin
          chk("extra_beat", 32'(bus.mem_req), 32'h0);
        end else begin
          e = exp_beats[0];
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_we", 32'(bus.mem_we), 32'(e.we));
          chk("mem_wdata", bus.mem_wdata, e.wdata);
          if (waitc == dly) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hA0 + 32'(e.beat);
            void'(exp_beats.pop_front());
            acks++;
            waitc = 0;
            if (acks == drop_after) bus.ic_req = 1'b0;
          end else begin
            waitc++;
          end
        end
      end
      if (!got_done) @(negedge clk);
    end
    if (!got_done) chk("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_ni      = 1'b0;
    bus.ic_req    = 1'b0;
    bus.ic_addr   = 32'h0;
    bus.dc_req    = 1'b0;
    bus.dc_we     = 1'b0;
    bus.dc_addr   = 32'h0;
    bus.dc_wdata  = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_grants", 32'({bus.ic_grant, bus.dc_grant}), 32'h0);
    chk("rst_mem_req", 32'({bus.mem_req, bus.mem_we}), 32'h0);
    chk("rst_pulses", 32'({bus.ic_rvalid, bus.dc_rvalid, bus.ic_done, bus.dc_done}), 32'h0);
    chk("rst_beat", 32'({bus.beat, bus.rbeat}), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    reset_ni = 1'b1;
    @(negedge clk);

    // icache line fill, ack every cycle
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_1234;
    expect_burst(32'h0000_1234, 1'b0);
    @(negedge clk);
    chk("ic_grant_latency", 32'(bus.ic_grant), 32'h1);
    chk("ic_first_beat", 32'(bus.beat), 32'h0);
    serve(1'b0, 0, -1);
    bus.ic_req = 1'b0;
    @(negedge clk);
    chk("ic_done_single", 32'(bus.ic_done), 32'h0);
    chk("idle_after_ic", 32'(bus.busy), 32'h0);

    // simultaneous requests: dcache first (last owner icache), then icache after one idle cycle
    bus.ic_req  = 1'b1;
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h0000_0200;
    expect_burst(32'h0000_0200, 1'b0);
    @(negedge clk);
    chk("tie1_dc_grant", 32'(bus.dc_grant), 32'h1);
    serve(1'b1, 0, -1);
    bus.dc_req = 1'b0;
    @(negedge clk);
    chk("gap_idle", 32'(bus.busy), 32'h0);
    chk("gap_ic_grant", 32'(bus.ic_grant), 32'h0);
    expect_burst(32'h0000_1234, 1'b0);
    @(negedge clk);
    chk("ic_after_gap", 32'(bus.ic_grant), 32'h1);
    serve(1'b0, 0, -1);
    bus.ic_req = 1'b0;
    @(negedge clk);
    bus.ic_req = 1'b1;
    bus.dc_req = 1'b1;
    expect_burst(32'h0000_0200, 1'b0);
    @(negedge clk);
    chk("tie2_dc_grant", 32'(bus.dc_grant), 32'h1);
    serve(1'b1, 0, -1);
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    @(negedge clk);

    // dcache writeback with three wait states per beat
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b1;
    bus.dc_addr = 32'h0000_0080;
    expect_burst(32'h0000_0080, 1'b1);
    @(negedge clk);
    serve(1'b1, 3, -1);
    bus.dc_req = 1'b0;
    bus.dc_we  = 1'b0;
    @(negedge clk);

    // icache drops its request after the second beat; burst still completes
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_5670;
    expect_burst(32'h0000_5670, 1'b0);
    @(negedge clk);
    serve(1'b0, 1, 2);
    @(negedge clk);

    // reset asserted during beat 2 of a dcache fill
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h0000_0300;
    bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("abort_at_beat2", 32'(bus.beat), 32'h2);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 32'h0);
    chk("abort_dc_grant", 32'(bus.dc_grant), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    bus.dc_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.dc_done), 32'h0);
    end
    reset_ni = 1'b1;
    @(negedge clk);

    // spurious ack while idle
    bus.mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("spur_busy", 32'(bus.busy), 32'h0);
      chk("spur_rvalid", 32'({bus.ic_rvalid, bus.dc_rvalid}), 32'h0);
      chk("spur_rdata", bus.rdata, 32'h0);
    end
    bus.mem_ack = 1'b0;

    // fresh icache fill after reset starts at beat 0
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_4008;
    expect_burst(32'h0000_4008, 1'b0);
    @(negedge clk);
    chk("fresh_beat0", 32'(bus.beat), 32'h0);
    serve(1'b0, 1, -1);
    bus.ic_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
